// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types and default constants for the PWM decoder sequencer.
package pwm_ctrl_pkg;
    localparam int SYM_W             = 8;
    localparam int SAMPLE_W          = 16;
    localparam int SYMBOL_LEN_DEF    = 64;
    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int ARM_TIMEOUT_DEF   = 1023;
    localparam logic signed [SAMPLE_W-1:0] REF_THRESH_DEF = 16'sd20;
    typedef enum logic [2:0] {IDLE, ARMED, COUNT, SETTLE, CAPTURE} state_t;
endpackage

// File: rtl/pwm_decoder_ctrl_if.sv
// pwm_decoder_ctrl_if: decoded-symbol stream (sym_data/sym_last/sym_valid from the producer, sym_ready from the consumer).
interface pwm_decoder_ctrl_if;
    import pwm_ctrl_pkg::*;
    logic signed [SYM_W-1:0] sym_data;
    logic                    sym_last;
    logic                    sym_valid;
    logic                    sym_ready;
    modport master (output sym_data, sym_last, sym_valid, input sym_ready);
    modport slave  (input sym_data, sym_last, sym_valid, output sym_ready);
endinterface

// File: rtl/pwm_decoder_ctrl_sym_fifo2.sv
// sym_fifo2: 2-entry first-word-fall-through FIFO; push/push_data/full on the write side, out_valid/out_data/out_ready on the read side; all outputs registered.
module sym_fifo2 (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [8:0] push_data,
    output logic       full,
    output logic       out_valid,
    output logic [8:0] out_data,
    input  logic       out_ready
);
    logic [8:0] r1;
    logic [1:0] cnt, cnt_nxt;
    logic       pop, push_ok, wr0, wr1, shift;
    always_comb begin
        pop     = out_valid && out_ready;
        push_ok = push && (!full || pop);
        cnt_nxt = cnt + {1'b0, push_ok} - {1'b0, pop};
        // out_data is the head entry; r1 holds the second entry when two are queued
        wr0     = push_ok && (cnt == 2'd0 || (cnt == 2'd1 && pop));
        wr1     = push_ok && (cnt == 2'd2 || (cnt == 2'd1 && !pop));
        shift   = pop && cnt == 2'd2;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            full      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            r1        <= '0;
        end else begin
            cnt       <= cnt_nxt;
            full      <= cnt_nxt == 2'd2;
            out_valid <= cnt_nxt != 2'd0;
            out_data  <= shift ? r1 : wr0 ? push_data : out_data;
            r1        <= wr1 ? push_data : r1;
        end
    end
endmodule

// File: rtl/pwm_decoder_ctrl.sv
// pwm_decoder_ctrl: arms on ref_in, gates the decoder enable window per symbol, captures decoded_symbol and streams a frame out.
// Ports: clock/reset; start+frame_len request a frame; ref_in arms; enable_counter/decoded_symbol talk to the decoder;
// sym (master) carries symbols; busy/done/timeout/overflow report status.
module pwm_decoder_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int SYMBOL_LEN    = SYMBOL_LEN_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter logic signed [SAMPLE_W-1:0] REF_THRESH = REF_THRESH_DEF,
    parameter int ARM_TIMEOUT   = ARM_TIMEOUT_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [7:0]                 frame_len,
    input  logic signed [SAMPLE_W-1:0] ref_in,
    output logic                       enable_counter,
    input  logic signed [SYM_W-1:0]    decoded_symbol,
    pwm_decoder_ctrl_if.master         sym,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic                       overflow
);
    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [7:0]  idx, flen;
    logic        q, qual, arm_go, arm_end, sym_end, set_end, is_last, start_ok, push, full, pop;
    logic        en_d, busy_d, done_d, to_d;
    logic [8:0]  word;
    always_comb begin
        qual     = ref_in > REF_THRESH;
        arm_go   = qual && q;
        arm_end  = cnt == 16'(ARM_TIMEOUT - 1);
        sym_end  = cnt == 16'(SYMBOL_LEN - 1);
        set_end  = cnt == 16'(SETTLE_CYCLES - 1);
        is_last  = idx == flen - 8'd1;
        start_ok = state == IDLE && start && frame_len != 8'd0;
        push     = state == CAPTURE;
        pop      = sym.sym_valid && sym.sym_ready;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start_ok ? ARMED : IDLE;
            ARMED:   state_nxt = arm_go ? COUNT : arm_end ? IDLE : ARMED;
            COUNT:   state_nxt = sym_end ? SETTLE : COUNT;
            SETTLE:  state_nxt = set_end ? CAPTURE : SETTLE;
            CAPTURE: state_nxt = is_last ? IDLE : COUNT;
            default: state_nxt = IDLE;
        endcase
    end
    // Output values are computed from the next state so the registered outputs line up with it
    always_comb begin
        en_d   = state_nxt == COUNT;
        busy_d = state_nxt != IDLE;
        done_d = (state == IDLE && start && frame_len == 8'd0) || (state == CAPTURE && is_last);
        to_d   = state == ARMED && !arm_go && arm_end;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            q              <= 1'b0;
            idx            <= '0;
            flen           <= '0;
            enable_counter <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout        <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            // Per-state cycle counter restarts on every state change
            cnt            <= (state_nxt != state || state == IDLE) ? '0 : cnt + 16'd1;
            // First half of the two-sample arm debounce
            q              <= state == ARMED && qual;
            idx            <= start_ok ? '0 : push ? idx + 8'd1 : idx;
            flen           <= start_ok ? frame_len : flen;
            enable_counter <= en_d;
            busy           <= busy_d;
            done           <= done_d;
            timeout        <= to_d;
            overflow       <= start_ok ? 1'b0 : (push && full && !pop) ? 1'b1 : overflow;
        end
    end
    sym_fifo2 u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data ({is_last, decoded_symbol}),
        .full      (full),
        .out_valid (sym.sym_valid),
        .out_data  (word),
        .out_ready (sym.sym_ready)
    );
    assign sym.sym_data = $signed(word[7:0]);
    assign sym.sym_last = word[8];
endmodule

// File: tb/tb_pwm_decoder_ctrl.sv
// tb_pwm_decoder_ctrl: directed self-checking bench for pwm_decoder_ctrl (SYMBOL_LEN=8, SETTLE_CYCLES=2, ARM_TIMEOUT=16).
module tb_pwm_decoder_ctrl;
    logic              clock = 1'b0, reset = 1'b0, start = 1'b0;
    logic [7:0]        frame_len = 8'd0;
    logic signed [15:0] ref_in = 16'sd0;
    logic signed [7:0] decoded_symbol = 8'sd0;
    logic              enable_counter, busy, done, timeout, overflow;
    int checks = 0, errors = 0;
    int cyc = 0, en_cnt = 0, done_cnt = 0, to_cnt = 0, busy_cnt = 0;
    int bq_data[$];
    int bq_last[$];
    int bq_cyc[$];

    pwm_decoder_ctrl_if sif();

    pwm_decoder_ctrl #(.SYMBOL_LEN(8), .SETTLE_CYCLES(2), .ARM_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .start(start), .frame_len(frame_len), .ref_in(ref_in),
        .enable_counter(enable_counter), .decoded_symbol(decoded_symbol), .sym(sif),
        .busy(busy), .done(done), .timeout(timeout), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Observe outputs mid-cycle; a beat is recorded when valid and ready are both high.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (enable_counter) en_cnt = en_cnt + 1;
        if (done) done_cnt = done_cnt + 1;
        if (timeout) to_cnt = to_cnt + 1;
        if (busy) busy_cnt = busy_cnt + 1;
        if (sif.sym_valid && sif.sym_ready) begin
            bq_data.push_back(int'(sif.sym_data));
            bq_last.push_back(int'(sif.sym_last));
            bq_cyc.push_back(cyc);
        end
    end

    task automatic step;
        @(posedge clock);
        #2;
    endtask

    task automatic clear_mon;
        en_cnt = 0; done_cnt = 0; to_cnt = 0; busy_cnt = 0;
        bq_data.delete(); bq_last.delete(); bq_cyc.delete();
    endtask

    function automatic int bd(int i);
        return (bq_data.size() > i) ? bq_data[i] : -999;
    endfunction

    function automatic int bl(int i);
        return (bq_last.size() > i) ? bq_last[i] : 2;
    endfunction

    function automatic int bc(int i);
        return (bq_cyc.size() > i) ? bq_cyc[i] : -999;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        sif.sym_ready = 1'b0;
        repeat (2) step();
        checks++;
        if ({enable_counter, sif.sym_valid, sif.sym_data, sif.sym_last, busy, done, timeout, overflow} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0000", {enable_counter, sif.sym_valid, sif.sym_data, sif.sym_last, busy, done, timeout, overflow});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single;
        clear_mon();
        frame_len = 8'd1; ref_in = 16'sd30; decoded_symbol = 8'sd5; sif.sym_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b expected 1", busy); end
        repeat (1) step();
        checks++;
        if (enable_counter !== 1'b0) begin errors++; $display("FAIL single_arm_early: enable_counter=%b expected 0", enable_counter); end
        step();
        checks++;
        if (enable_counter !== 1'b1) begin errors++; $display("FAIL single_arm_latency: enable_counter=%b expected 1", enable_counter); end
        repeat (11) step();
        checks++;
        if ({done, busy, sif.sym_valid, sif.sym_data, sif.sym_last} !== {1'b1, 1'b0, 1'b1, 8'sd5, 1'b1}) begin
            errors++;
            $display("FAIL single_frame_end: done=%b busy=%b valid=%b data=%0d last=%b expected 1 0 1 5 1", done, busy, sif.sym_valid, sif.sym_data, sif.sym_last);
        end
        step();
        checks++;
        if ({done, sif.sym_valid} !== 2'b00) begin errors++; $display("FAIL single_after: done=%b valid=%b expected 0 0", done, sif.sym_valid); end
        checks++;
        if (en_cnt !== 8) begin errors++; $display("FAIL single_enable_len: got %0d expected 8", en_cnt); end
        checks++;
        if (done_cnt !== 1 || bq_data.size() !== 1 || bd(0) !== 5 || bl(0) !== 1) begin
            errors++;
            $display("FAIL single_beat: done_cnt=%0d beats=%0d data=%0d last=%0d expected 1 1 5 1", done_cnt, bq_data.size(), bd(0), bl(0));
        end
    endtask

    task automatic test_back_to_back;
        clear_mon();
        frame_len = 8'd3; ref_in = 16'sd30; decoded_symbol = -8'sd3; sif.sym_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        decoded_symbol = 8'sd7;
        repeat (11) step();
        decoded_symbol = 8'sd12;
        repeat (11) step();
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL b2b_done: done=%b busy=%b expected 1 0", done, busy); end
        frame_len = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_on_done: busy=%b expected 1", busy); end
        repeat (15) step();
        checks++;
        if (bq_data.size() !== 4 || bd(0) !== -3 || bd(1) !== 7 || bd(2) !== 12 || bd(3) !== 12) begin
            errors++;
            $display("FAIL b2b_data: beats=%0d data=%0d,%0d,%0d,%0d expected 4 -3,7,12,12", bq_data.size(), bd(0), bd(1), bd(2), bd(3));
        end
        checks++;
        if (bl(0) !== 0 || bl(1) !== 0 || bl(2) !== 1 || bl(3) !== 1) begin
            errors++;
            $display("FAIL b2b_last: last=%0d,%0d,%0d,%0d expected 0,0,1,1", bl(0), bl(1), bl(2), bl(3));
        end
        checks++;
        if (bc(1) - bc(0) !== 11 || bc(2) - bc(1) !== 11) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d expected 11,11", bc(1) - bc(0), bc(2) - bc(1));
        end
        checks++;
        if (en_cnt !== 32 || done_cnt !== 2) begin errors++; $display("FAIL b2b_counts: en=%0d done=%0d expected 32 2", en_cnt, done_cnt); end
    endtask

    task automatic test_timeout;
        clear_mon();
        frame_len = 8'd1; ref_in = 16'sd20; start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        checks++;
        if ({timeout, busy} !== 2'b01) begin errors++; $display("FAIL timeout_early: timeout=%b busy=%b expected 0 1", timeout, busy); end
        step();
        checks++;
        if ({timeout, busy} !== 2'b10) begin errors++; $display("FAIL timeout_pulse: timeout=%b busy=%b expected 1 0", timeout, busy); end
        step();
        checks++;
        if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_one_cycle: timeout=%b expected 0", timeout); end
        repeat (3) step();
        checks++;
        if (en_cnt !== 0 || to_cnt !== 1) begin errors++; $display("FAIL timeout_counts: en=%0d to=%0d expected 0 1", en_cnt, to_cnt); end
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 22; i++) begin
            ref_in = (i % 2 == 0) ? 16'sd0 : 16'sd30;
            step();
        end
        checks++;
        if (en_cnt !== 0 || to_cnt !== 1) begin errors++; $display("FAIL debounce_alternating: en=%0d to=%0d expected 0 1", en_cnt, to_cnt); end
        ref_in = 16'sd30;
    endtask

    task automatic test_backpressure;
        clear_mon();
        frame_len = 8'd4; ref_in = 16'sd30; decoded_symbol = 8'sd1; sif.sym_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        decoded_symbol = 8'sd2;
        checks++;
        if ({sif.sym_valid, sif.sym_data} !== {1'b1, 8'sd1}) begin errors++; $display("FAIL bp_first: valid=%b data=%0d expected 1 1", sif.sym_valid, sif.sym_data); end
        repeat (11) step();
        decoded_symbol = 8'sd3;
        checks++;
        if ({sif.sym_data, overflow} !== {8'sd1, 1'b0}) begin errors++; $display("FAIL bp_full_no_drop: data=%0d overflow=%b expected 1 0", sif.sym_data, overflow); end
        repeat (11) step();
        decoded_symbol = 8'sd4;
        checks++;
        if ({sif.sym_data, overflow} !== {8'sd1, 1'b1}) begin errors++; $display("FAIL bp_drop: data=%0d overflow=%b expected 1 1", sif.sym_data, overflow); end
        repeat (11) step();
        checks++;
        if ({done, overflow, sif.sym_valid, sif.sym_data, sif.sym_last} !== {1'b1, 1'b1, 1'b1, 8'sd1, 1'b0}) begin
            errors++;
            $display("FAIL bp_end: done=%b ovf=%b valid=%b data=%0d last=%b expected 1 1 1 1 0", done, overflow, sif.sym_valid, sif.sym_data, sif.sym_last);
        end
        sif.sym_ready = 1'b1;
        step();
        checks++;
        if ({sif.sym_valid, sif.sym_data, sif.sym_last} !== {1'b1, 8'sd2, 1'b0}) begin
            errors++;
            $display("FAIL bp_second: valid=%b data=%0d last=%b expected 1 2 0", sif.sym_valid, sif.sym_data, sif.sym_last);
        end
        step();
        checks++;
        if (sif.sym_valid !== 1'b0 || bq_data.size() !== 2 || bd(0) !== 1 || bd(1) !== 2) begin
            errors++;
            $display("FAIL bp_drain: valid=%b beats=%0d data=%0d,%0d expected 0 2 1,2", sif.sym_valid, bq_data.size(), bd(0), bd(1));
        end
        frame_len = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow_clear: overflow=%b expected 0", overflow); end
        repeat (15) step();
    endtask

    task automatic test_full_push_pop;
        clear_mon();
        frame_len = 8'd3; ref_in = 16'sd30; decoded_symbol = 8'sd1; sif.sym_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        decoded_symbol = 8'sd2;
        repeat (11) step();
        decoded_symbol = 8'sd3;
        repeat (10) step();
        sif.sym_ready = 1'b1;
        step();
        checks++;
        if ({overflow, done, sif.sym_valid, sif.sym_data} !== {1'b0, 1'b1, 1'b1, 8'sd2}) begin
            errors++;
            $display("FAIL fpp_simul: ovf=%b done=%b valid=%b data=%0d expected 0 1 1 2", overflow, done, sif.sym_valid, sif.sym_data);
        end
        repeat (3) step();
        checks++;
        if (bq_data.size() !== 3 || bd(0) !== 1 || bd(1) !== 2 || bd(2) !== 3 || bl(1) !== 0 || bl(2) !== 1) begin
            errors++;
            $display("FAIL fpp_beats: beats=%0d data=%0d,%0d,%0d last=%0d,%0d expected 3 1,2,3 0,1", bq_data.size(), bd(0), bd(1), bd(2), bl(1), bl(2));
        end
    endtask

    task automatic test_reset_mid;
        frame_len = 8'd3; ref_in = 16'sd30; decoded_symbol = 8'sd9; sif.sym_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (16) step();
        checks++;
        if ({enable_counter, sif.sym_valid} !== 2'b11) begin errors++; $display("FAIL rst_pre: en=%b valid=%b expected 1 1", enable_counter, sif.sym_valid); end
        reset = 1'b1;
        #1;
        checks++;
        if ({enable_counter, sif.sym_valid, sif.sym_data, sif.sym_last, busy, done, timeout, overflow} !== 15'd0) begin
            errors++;
            $display("FAIL rst_async: got %h expected 0000", {enable_counter, sif.sym_valid, sif.sym_data, sif.sym_last, busy, done, timeout, overflow});
        end
        step();
        reset = 1'b0;
        clear_mon();
        frame_len = 8'd1; decoded_symbol = 8'sd4; sif.sym_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (15) step();
        checks++;
        if (bq_data.size() !== 1 || bd(0) !== 4 || bl(0) !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL rst_rerun: beats=%0d data=%0d last=%0d done=%0d expected 1 4 1 1", bq_data.size(), bd(0), bl(0), done_cnt);
        end
    endtask

    task automatic test_edge;
        clear_mon();
        frame_len = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin errors++; $display("FAIL zero_len_done: done=%b busy=%b expected 1 0", done, busy); end
        step();
        checks++;
        if (done !== 1'b0 || busy_cnt !== 0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL zero_len_after: done=%b busy_cycles=%0d dones=%0d expected 0 0 1", done, busy_cnt, done_cnt);
        end
        clear_mon();
        frame_len = 8'd2; ref_in = 16'sd30; decoded_symbol = 8'sd6; sif.sym_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        frame_len = 8'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (22) step();
        checks++;
        if (bq_data.size() !== 2 || bl(0) !== 0 || bl(1) !== 1 || done_cnt !== 1) begin
            errors++;
            $display("FAIL start_while_busy: beats=%0d last=%0d,%0d dones=%0d expected 2 0,1 1", bq_data.size(), bl(0), bl(1), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_full_push_pop();
        test_reset_mid();
        test_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
